line_memory_backend: RTL

//  Cache-line-granular external memory model/backend; directly downstream of memory_controller's mem_* port.

---
 rtl/line_memory_backend.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/line_memory_backend.sv
// Line-granular memory backend: 64B lines stored in an internal array, in-order responses via a bounded queue.
// Latency: a request accepted at edge T raises mem_resp_valid at cycle T+LATENCY (later if the consumer stalls).
// Backpressure: mem_req_ready drops while MAX_OUTSTANDING responses are queued; responses hold until mem_resp_ready.
module line_memory_backend #(
    parameter int ADDR_WIDTH      = 48,
    parameter int LINE_WORDS      = 8,
    parameter int MEM_LINES       = 1024,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_write,
    input  logic [63:0]           mem_wdata [0:LINE_WORDS-1],
    input  logic                  mem_req_valid,
    output logic                  mem_req_ready,
    output logic [63:0]           mem_rdata [0:LINE_WORDS-1],
    output logic                  mem_resp_valid,
    input  logic                  mem_resp_ready,
    output logic                  err_oor,
    output logic [31:0]           resp_count
);

    localparam int OFFSET_BITS = 6;
    localparam int IDX_BITS    = $clog2(MEM_LINES);
    localparam int LINE_BITS   = ADDR_WIDTH - OFFSET_BITS;
    localparam int CNT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [LINE_BITS-1:0] LINES_LIM  = LINE_BITS'(MEM_LINES);
    localparam logic [CNT_W-1:0]     MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]     PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [7:0]           TIMER_LOAD = 8'(LATENCY - 1);
    localparam logic [63:0]          OOR_WORD   = 64'hDEAD_BEEF_DEAD_BEEF;

    // Line storage; deliberately never reset so contents survive a reset pulse.
    logic [63:0] mem_array [0:MEM_LINES-1][0:LINE_WORDS-1];

    // Response queue: one line of data plus a countdown timer per entry.
    logic [63:0] q_data  [0:MAX_OUTSTANDING-1][0:LINE_WORDS-1];
    logic [7:0]  q_timer [0:MAX_OUTSTANDING-1];

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    rd_ptr_nxt;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic [CNT_W-1:0]    remain;
    logic                fire;
    logic                pop;
    logic                in_range;
    logic                valid_nxt;
    logic [IDX_BITS-1:0] idx;
    logic [63:0]         push_data [0:LINE_WORDS-1];
    logic                unused_offset;

    // The byte offset within the line plays no part in addressing.
    assign unused_offset = ^mem_addr[OFFSET_BITS-1:0];

    // Ready depends only on the registered occupancy, so a pop never frees a slot in the same cycle.
    assign mem_req_ready = (count < MAX_CNT);
    assign fire          = mem_req_valid && mem_req_ready;
    assign pop           = mem_resp_valid && mem_resp_ready;
    assign idx           = mem_addr[OFFSET_BITS +: IDX_BITS];
    assign in_range      = (mem_addr[ADDR_WIDTH-1:OFFSET_BITS] < LINES_LIM);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Data captured on push: write echo, stored line (pre-edge contents), or the out-of-range marker.
    always_comb begin
        for (int w = 0; w < LINE_WORDS; w++) begin
            push_data[w] = OOR_WORD;
            if (mem_write) begin
                push_data[w] = mem_wdata[w];
            end else if (in_range) begin
                push_data[w] = mem_array[idx][w];
            end
        end
    end

    // Next queue state; the registered response looks at the head that remains after this cycle's pop.
    always_comb begin
        rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
        remain     = count - CNT_W'(pop);
        count_nxt  = remain + CNT_W'(fire);
        valid_nxt  = (remain != '0) && (q_timer[rd_ptr_nxt] == 8'd0);
    end

    // Write accepted in-range lines into storage on the accept edge.
    always_ff @(posedge clk) begin
        if (fire && mem_write && in_range) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                mem_array[idx][w] <= mem_wdata[w];
            end
        end
    end

    // Capture pushed line data into the queue slot at the write pointer.
    always_ff @(posedge clk) begin
        if (fire) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                q_data[wr_ptr][w] <= push_data[w];
            end
        end
    end

    // Queue control, timers, registered response, error pulse and delivery counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            mem_resp_valid <= 1'b0;
            err_oor        <= 1'b0;
            resp_count     <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_timer[i] <= 8'd0;
            end
            for (int w = 0; w < LINE_WORDS; w++) begin
                mem_rdata[w] <= 64'd0;
            end
        end else begin
            count          <= count_nxt;
            rd_ptr         <= rd_ptr_nxt;
            mem_resp_valid <= valid_nxt;
            err_oor        <= fire && !in_range;
            if (fire) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                resp_count <= resp_count + 32'd1;
            end
            // All timers count down in parallel, even while the head is stalled.
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (fire && (wr_ptr == PTR_W'(i))) begin
                    q_timer[i] <= TIMER_LOAD;
                end else if (q_timer[i] != 8'd0) begin
                    q_timer[i] <= q_timer[i] - 8'd1;
                end
            end
            if (valid_nxt) begin
                for (int w = 0; w < LINE_WORDS; w++) begin
                    mem_rdata[w] <= q_data[rd_ptr_nxt][w];
                end
            end
        end
    end

endmodule
